// File: rtl/hazard_ctrl_pkg.sv
// Shared core constants and hazard-controller state encoding.
// The enum is the trace-visible view; the localparams are what the FSM logic compares against.
package hazard_ctrl_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [REGW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        HS_RUN       = 2'd0,
        HS_HOLD      = 2'd1,
        HS_HOLD_PEND = 2'd2
    } hazard_state_e;

    localparam logic [1:0] ST_RUN       = HS_RUN;
    localparam logic [1:0] ST_HOLD      = HS_HOLD;
    localparam logic [1:0] ST_HOLD_PEND = HS_HOLD_PEND;

endpackage

// File: rtl/event_counter.sv
// Free-running event counter: counts enabled cycles, wraps modulo 2^WIDTH.
module event_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = en_i ? cnt_q + WIDTH'(1) : cnt_q;
    end

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX branch redirects, memory freeze
// with deferred replay of a redirect that arrives while frozen, plus event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN = hazard_ctrl_pkg::XLEN,
    parameter int REGW = hazard_ctrl_pkg::REGW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [REGW-1:0] id_rs1_i,
    input  logic [REGW-1:0] id_rs2_i,
    input  logic            id_use_rs1_i,
    input  logic            id_use_rs2_i,
    input  logic            ex_memread_i,
    input  logic [REGW-1:0] ex_rd_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            mem_stall_i,
    output logic            pc_write_o,
    output logic            pc_redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            if_id_stall_o,
    output logic            if_id_flush_o,
    output logic            id_ex_flush_o,
    output logic            pipe_hold_o,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            load_use;

    assign load_use = ex_memread_i && (ex_rd_i != REGW'(REG_ZERO)) &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_d       = ST_RUN;
        pend_pc_d     = pend_pc_q;
        pc_write_o    = 1'b1;
        pc_redirect_o = 1'b0;
        redirect_pc_o = pend_pc_q;
        if_id_stall_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        pipe_hold_o   = 1'b0;

        if (!rst_i) begin
            state_d = ST_RUN;
        end else if (mem_stall_i) begin
            pc_write_o    = 1'b0;
            if_id_stall_o = 1'b1;
            pipe_hold_o   = 1'b1;
            // Only the first redirect seen during a freeze is kept.
            if (state_q == ST_HOLD_PEND) begin
                state_d = ST_HOLD_PEND;
            end else if (branch_taken_i) begin
                pend_pc_d = branch_target_i;
                state_d   = ST_HOLD_PEND;
            end else begin
                state_d = ST_HOLD;
            end
        end else if (state_q == ST_HOLD_PEND) begin
            pc_redirect_o = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (branch_taken_i) begin
            pc_redirect_o = 1'b1;
            redirect_pc_o = branch_target_i;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_RUN;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    event_counter #(.WIDTH(32)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (!pc_write_o),
        .cnt_o (stall_cnt_o)
    );

    event_counter #(.WIDTH(32)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (if_id_flush_o),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of per-cycle vectors with expected controls,
// a scoreboard queue of expectations, and a hand sequence for counter wrap.
module tb_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
    logic        id_use_rs1_i, id_use_rs2_i, ex_memread_i;
    logic        branch_taken_i, mem_stall_i;
    logic [31:0] branch_target_i;
    logic        pc_write_o, pc_redirect_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, pipe_hold_o;
    logic [31:0] redirect_pc_o, stall_cnt_o, flush_cnt_o;

    hazard_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .id_rs1_i        (id_rs1_i),
        .id_rs2_i        (id_rs2_i),
        .id_use_rs1_i    (id_use_rs1_i),
        .id_use_rs2_i    (id_use_rs2_i),
        .ex_memread_i    (ex_memread_i),
        .ex_rd_i         (ex_rd_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .mem_stall_i     (mem_stall_i),
        .pc_write_o      (pc_write_o),
        .pc_redirect_o   (pc_redirect_o),
        .redirect_pc_o   (redirect_pc_o),
        .if_id_stall_o   (if_id_stall_o),
        .if_id_flush_o   (if_id_flush_o),
        .id_ex_flush_o   (id_ex_flush_o),
        .pipe_hold_o     (pipe_hold_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // ctrl bit order: {pc_write, pc_redirect, if_id_stall, if_id_flush, id_ex_flush, pipe_hold}
    localparam logic [5:0] C_NORM  = 6'b100000;
    localparam logic [5:0] C_LU    = 6'b001010;
    localparam logic [5:0] C_REDIR = 6'b110110;
    localparam logic [5:0] C_FRZ   = 6'b001001;

    typedef struct {
        string       name;
        logic        rst;
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2, memread, bt, mstall;
        logic [31:0] target;
        logic [5:0]  exp_ctrl;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        string       name;
        logic [5:0]  ctrl;
        logic [31:0] pc;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] m_stall = 0;
    logic [31:0] m_flush = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input string name, input logic rst,
                                input logic memread, input logic [4:0] rd,
                                input logic use1, input logic [4:0] rs1,
                                input logic use2, input logic [4:0] rs2,
                                input logic bt, input logic [31:0] target, input logic mstall,
                                input logic [5:0] exp_ctrl, input logic [31:0] exp_pc);
        vec_t v;
        v.name = name; v.rst = rst; v.memread = memread; v.rd = rd;
        v.use1 = use1; v.rs1 = rs1; v.use2 = use2; v.rs2 = rs2;
        v.bt = bt; v.target = target; v.mstall = mstall;
        v.exp_ctrl = exp_ctrl; v.exp_pc = exp_pc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_i = v.rst; ex_memread_i = v.memread; ex_rd_i = v.rd;
        id_use_rs1_i = v.use1; id_rs1_i = v.rs1; id_use_rs2_i = v.use2; id_rs2_i = v.rs2;
        branch_taken_i = v.bt; branch_target_i = v.target; mem_stall_i = v.mstall;
    endtask

    // Drive one cycle, push expectation, then pop and compare once outputs settle.
    task automatic step(input vec_t v);
        exp_t e, got;
        @(negedge clk_i);
        drive(v);
        e.name = v.name; e.ctrl = v.exp_ctrl; e.pc = v.exp_pc;
        e.scnt = m_stall; e.fcnt = m_flush;
        sb.push_back(e);
        if (!v.rst) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (!v.exp_ctrl[5]) m_stall = m_stall + 1;
            if (v.exp_ctrl[2])  m_flush = m_flush + 1;
        end
        #1;
        got = sb.pop_front();
        check({got.name, ".ctrl"}, 64'({pc_write_o, pc_redirect_o, if_id_stall_o,
                                          if_id_flush_o, id_ex_flush_o, pipe_hold_o}), 64'(got.ctrl));
        check({got.name, ".pc"},   64'(redirect_pc_o), 64'(got.pc));
        check({got.name, ".cnt"},  {stall_cnt_o, flush_cnt_o}, {got.scnt, got.fcnt});
    endtask

    initial begin
        // name, rst, memread, rd, use1, rs1, use2, rs2, bt, target, mstall, ctrl, pc
        vecs.push_back(mk("reset",        0, 0, 0, 0, 0, 0, 0, 0, 0,      0, C_NORM,  0));
        vecs.push_back(mk("idle",         1, 0, 0, 0, 0, 0, 0, 0, 0,      0, C_NORM,  0));
        vecs.push_back(mk("lu_rs2_x5",    1, 1, 5, 0, 0, 1, 5, 0, 0,      0, C_LU,    0));
        vecs.push_back(mk("after_lu",     1, 0, 5, 0, 0, 1, 5, 0, 0,      0, C_NORM,  0));
        vecs.push_back(mk("load_x0",      1, 1, 0, 1, 0, 1, 0, 0, 0,      0, C_NORM,  0));
        vecs.push_back(mk("lu_unused_rs", 1, 1, 7, 0, 7, 0, 7, 0, 0,      0, C_NORM,  0));
        vecs.push_back(mk("lu_rs1",       1, 1, 9, 1, 9, 0, 0, 0, 0,      0, C_LU,    0));
        vecs.push_back(mk("br_beats_lu",  1, 1, 5, 0, 0, 1, 5, 1, 32'h100, 0, C_REDIR, 32'h100));
        vecs.push_back(mk("post_br",      1, 0, 0, 0, 0, 0, 0, 0, 0,      0, C_NORM,  0));
        vecs.push_back(mk("frz1_br200",   1, 0, 0, 0, 0, 0, 0, 1, 32'h200, 1, C_FRZ,   0));
        vecs.push_back(mk("frz2_br300",   1, 0, 0, 0, 0, 0, 0, 1, 32'h300, 1, C_FRZ,   32'h200));
        vecs.push_back(mk("frz3",         1, 0, 0, 0, 0, 0, 0, 0, 0,      1, C_FRZ,   32'h200));
        vecs.push_back(mk("replay_200",   1, 0, 0, 0, 0, 0, 0, 0, 0,      0, C_REDIR, 32'h200));
        vecs.push_back(mk("post_replay",  1, 0, 0, 0, 0, 0, 0, 0, 0,      0, C_NORM,  32'h200));
        vecs.push_back(mk("frz_beats_lu", 1, 1, 5, 1, 5, 0, 0, 0, 0,      1, C_FRZ,   32'h200));
        vecs.push_back(mk("lu_after_frz", 1, 1, 5, 1, 5, 0, 0, 0, 0,      0, C_LU,    32'h200));
        vecs.push_back(mk("idle2",        1, 0, 0, 0, 0, 0, 0, 0, 0,      0, C_NORM,  32'h200));
        vecs.push_back(mk("hold",         1, 0, 0, 0, 0, 0, 0, 0, 0,      1, C_FRZ,   32'h200));
        vecs.push_back(mk("hold_br400",   1, 0, 0, 0, 0, 0, 0, 1, 32'h400, 0, C_REDIR, 32'h400));
        vecs.push_back(mk("idle3",        1, 0, 0, 0, 0, 0, 0, 0, 0,      0, C_NORM,  32'h200));
        vecs.push_back(mk("frz_br500",    1, 0, 0, 0, 0, 0, 0, 1, 32'h500, 1, C_FRZ,   32'h200));
        vecs.push_back(mk("replay_ign600",1, 0, 0, 0, 0, 0, 0, 1, 32'h600, 0, C_REDIR, 32'h500));
        vecs.push_back(mk("frz_br700",    1, 0, 0, 0, 0, 0, 0, 1, 32'h700, 1, C_FRZ,   32'h500));
        vecs.push_back(mk("rst_in_pend",  0, 1, 5, 1, 5, 0, 0, 1, 32'h800, 1, C_NORM,  32'h700));
        vecs.push_back(mk("no_replay",    1, 0, 0, 0, 0, 0, 0, 0, 0,      0, C_NORM,  0));

        drive(vecs[0]);
        repeat (2) @(posedge clk_i);
        foreach (vecs[i]) step(vecs[i]);

        // Counter wrap: preload stall counter at all-ones, then one load-use stall.
        @(negedge clk_i);
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_stall_cnt.cnt_q;
        drive(mk("wrap_lu", 1, 1, 5, 0, 0, 1, 5, 0, 0, 0, C_LU, 0));
        #1;
        check("wrap_pre", 64'(stall_cnt_o), 64'(32'hFFFF_FFFF));
        check("wrap_lu.ctrl", 64'({pc_write_o, if_id_stall_o, id_ex_flush_o}), 64'(3'b111 & 3'b011));
        @(negedge clk_i);
        drive(mk("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0));
        #1;
        check("wrap_post", 64'(stall_cnt_o), 64'(32'h0));
        check("wrap_flush_kept", 64'(flush_cnt_o), 64'(m_flush));

        if (sb.size() != 0) check("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It generates the stall, flush and PC-write controls for the PC register, the IF/ID register and the ID/EX register. It also produces the hold control for the downstream stages. It detects load-use hazards, applies branch redirects resolved in EX, and freezes the pipeline while data memory is busy. A branch redirect that arrives during a memory freeze is latched and replayed when the freeze releases. Two 32-bit event counters report stall and flush activity.

## Interface
Parameters:
- XLEN, 32, PC/target width
- REGW, 5, register index width

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-low reset
- id_rs1_i  in  REGW  rs1 of instruction in ID
- id_rs2_i  in  REGW  rs2 of instruction in ID
- id_use_rs1_i  in  1  ID instruction reads rs1
- id_use_rs2_i  in  1  ID instruction reads rs2
- ex_memread_i  in  1  instruction in EX is a load
- ex_rd_i  in  REGW  destination of instruction in EX
- branch_taken_i  in  1  single-cycle pulse: branch/jump in EX redirects
- branch_target_i  in  XLEN  redirect target, valid with branch_taken_i
- mem_stall_i  in  1  data memory busy; whole pipeline must freeze
- pc_write_o  out  1  PC register load enable
- pc_redirect_o  out  1  PC mux selects redirect_pc_o
- redirect_pc_o  out  XLEN  redirect target
- if_id_stall_o  out  1  IF/ID holds
- if_id_flush_o  out  1  IF/ID loads zeros
- id_ex_flush_o  out  1  ID/EX loads bubble
- pipe_hold_o  out  1  EX/MEM and MEM/WB hold
- stall_cnt_o  out  32  cycles with pc_write_o=0
- flush_cnt_o  out  32  cycles with if_id_flush_o=1

## Operation
- States: RUN, HOLD, HOLD_PEND. Reset state is RUN.
- Load-use hazard (lu) is defined as: ex_memread_i && ex_rd_i!=0 && ((id_use_rs1_i && id_rs1_i==ex_rd_i) || (id_use_rs2_i && id_rs2_i==ex_rd_i)).
- Priority, highest first: mem_stall_i, then pending/current redirect, then lu, then normal flow.
- mem_stall_i=1, in any state:
  - pc_write_o=0, if_id_stall_o=1, pipe_hold_o=1, all flushes 0, pc_redirect_o=0.
  - From RUN, go to HOLD.
  - If branch_taken_i=1, latch branch_target_i into pend_pc and go to HOLD_PEND.
  - HOLD_PEND stays in HOLD_PEND.
  - A second branch_taken_i while in HOLD_PEND is ignored; the first target is kept.
- RUN or HOLD with mem_stall_i=0 and branch_taken_i=1:
  - pc_write_o=1, pc_redirect_o=1, redirect_pc_o=branch_target_i.
  - if_id_flush_o=1, id_ex_flush_o=1.
  - Next state is RUN.
- HOLD_PEND with mem_stall_i=0:
  - Same outputs as a redirect, but redirect_pc_o=pend_pc. Any concurrent branch_taken_i is ignored.
  - Next state is RUN.
- No redirect, mem_stall_i=0, lu=1:
  - pc_write_o=0, if_id_stall_o=1, id_ex_flush_o=1.
  - Next state is RUN.
- Otherwise:
  - pc_write_o=1, all other controls 0.
  - Next state is RUN.
- redirect_pc_o equals pend_pc whenever not redirecting.
- Counters:
  - Each increments by 1 at the clock edge following a qualifying cycle.
  - Modulo 2^32: 0xFFFFFFFF wraps to 0.
  - Both saturate nowhere and are never cleared except by reset.
- Reset (rst_i=0 at an edge):
  - State goes to RUN, pend_pc=0, both counters=0.
  - A pending redirect is discarded.

## Timing
- All control outputs are combinational from current state and inputs, with zero-cycle latency, so IF/ID and ID/EX act at the same edge the hazard is seen.
- Control output values while rst_i=0: pc_write_o=1, all other controls 0, redirect_pc_o=pend_pc (0 after the first reset edge).
- A pending redirect applies in the first cycle with mem_stall_i=0 after the freeze; there are no idle cycles between.
- A load-use stall lasts exactly 1 cycle unless extended by mem_stall_i.
- Counter outputs are registered and reflect events up to the previous cycle.

## Structure
- The shared core package holds:
  - REGW
  - XLEN
  - REG_ZERO (5'd0)
  - the hazard-state enum, as a typedef used by debug/trace logic.
- Sub-module event_counter (32-bit, enable, sync active-low reset, wrap) is instantiated twice.
- The remaining logic (FSM, pend_pc register, output decode) stays in hazard_ctrl.

## Test plan
- Load x5 in EX, ID reads rs2=x5 -> one cycle with pc_write_o=0, if_id_stall_o=1, id_ex_flush_o=1; then normal flow; stall_cnt_o increments by 1.
- Load to x0 in EX, ID reads x0 -> no stall; pc_write_o=1 throughout.
- branch_taken_i with target 0x0000_0100 and lu=1 in the same cycle -> redirect wins; both flushes are 1, redirect_pc_o=0x100, no stall.
- mem_stall_i high for 3 cycles, with branch_taken_i (target 0x200) in the 1st of them and a second branch (0x300) in the 2nd -> 3 frozen cycles with pipe_hold_o=1; the next cycle redirects to 0x200; flush_cnt_o increments by 1; stall_cnt_o increments by 3.
- rst_i=0 during HOLD_PEND -> state RUN, no redirect after release, counters read 0.
- Force stall_cnt_o to 0xFFFFFFFF, then a load-use stall -> the counter reads 0 on the next cycle.
